// File: rtl/rvpipe_pkg.sv
// ============================================================================
// Module : rvpipe_pkg
// Brief  : Shared sizing helpers for the elastic pipeline register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rvpipe_pkg;

    // Occupancy counter must hold 0..DEPTH+1 (stages plus optional skid slot).
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvdff_skid_slot.sv
// ============================================================================
// Module : rvdff_skid_slot
// Brief  : One-entry input skid register; ready is a flop output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rvdff_skid_slot #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             drain,
    output logic             skid_valid,
    output logic [WIDTH-1:0] skid_data
);

    logic             r_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;
    logic             w_fill;
    logic             w_valid_nxt;

    // A beat is parked only when it is accepted but stage 0 cannot take it.
    assign w_fill      = in_valid & r_ready & ~r_valid & ~drain;
    assign w_valid_nxt = flush ? 1'b0 : (r_valid ? ~drain : w_fill);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_data  <= RESET_VAL;
        end else begin
            r_valid <= w_valid_nxt;
            r_ready <= ~w_valid_nxt;
            if (w_fill && !flush) begin
                r_data <= din;
            end
        end
    end

    assign in_ready   = r_ready;
    assign skid_valid = r_valid;
    assign skid_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/rvdff_pipe_elastic.sv
// ============================================================================
// Module : rvdff_pipe_elastic
// Brief  : DEPTH-stage valid/ready pipeline register with flush and skid slot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rvdff_pipe_elastic
    import rvpipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter int               REG_READY = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               din,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               dout,
    output logic [occ_width(DEPTH)-1:0]    occupancy
);

    localparam int                 c_occ_w   = occ_width(DEPTH);
    localparam logic [c_occ_w-1:0] c_occ_max = c_occ_w'(DEPTH + REG_READY);

    logic [DEPTH-1:0]   r_valid;
    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [DEPTH:0]     w_free;
    logic [DEPTH-1:0]   w_src_valid;
    logic [WIDTH-1:0]   w_src_data [DEPTH];
    logic [DEPTH-1:0]   w_valid_nxt;
    logic [DEPTH-1:0]   w_load;
    logic               w_s0_valid;
    logic [WIDTH-1:0]   w_s0_data;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_occ_w-1:0] r_occ;

    // A stage can accept when empty or when everything downstream of it moves.
    assign w_free[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign w_free[i] = ~r_valid[i] | w_free[i+1];

        if (i == 0) begin : g_head
            assign w_src_valid[i] = w_s0_valid;
            assign w_src_data[i]  = w_s0_data;
        end else begin : g_body
            assign w_src_valid[i] = r_valid[i-1];
            assign w_src_data[i]  = r_data[i-1];
        end

        assign w_valid_nxt[i] = flush ? 1'b0 : (w_free[i] ? w_src_valid[i] : r_valid[i]);
        assign w_load[i]      = ~flush & w_free[i] & w_src_valid[i];
    end

    if (REG_READY != 0) begin : g_skid
        logic             w_skid_valid;
        logic             w_skid_ready;
        logic [WIDTH-1:0] w_skid_data;

        rvdff_skid_slot #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_skid (
            .clk        (clk),
            .rst_l      (rst_l),
            .flush      (flush),
            .in_valid   (in_valid),
            .in_ready   (w_skid_ready),
            .din        (din),
            .drain      (w_free[0]),
            .skid_valid (w_skid_valid),
            .skid_data  (w_skid_data)
        );

        // Skid content always goes first so order is preserved.
        assign in_ready   = w_skid_ready;
        assign w_s0_valid = w_skid_valid | (in_valid & w_skid_ready);
        assign w_s0_data  = w_skid_valid ? w_skid_data : din;
    end else begin : g_no_skid
        assign in_ready   = w_free[0];
        assign w_s0_valid = in_valid;
        assign w_s0_data  = din;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else begin
            r_valid <= w_valid_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= w_src_data[i];
                end
            end
        end
    end

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + {{(c_occ_w-1){1'b0}}, w_in_xfer}
                           - {{(c_occ_w-1){1'b0}}, w_out_xfer};
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign dout      = r_data[DEPTH-1];
    assign occupancy = r_occ;

`ifndef SYNTHESIS
    a_occ_max: assert property (@(posedge clk) disable iff (!rst_l)
        r_occ <= c_occ_max);

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_l)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(dout)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvdff_pipe_elastic.sv
// ============================================================================
// Module : tb_rvdff_pipe_elastic
// Brief  : Directed self-checking bench for rvdff_pipe_elastic (two configs).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rvdff_pipe_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_l;
    int   errors = 0;
    int   checks = 0;

    // Instance A: DEPTH=2, registered ready
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_din, a_dout;
    logic [1:0]  a_occ;

    // Instance B: DEPTH=1, combinational ready
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_din, b_dout;
    logic [1:0]  b_occ;

    rvdff_pipe_elastic #(
        .WIDTH(32), .DEPTH(2), .REG_READY(1), .RESET_VAL(32'hDEAD_BEEF)
    ) u_dut_a (
        .clk(clk), .rst_l(rst_l), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout),
        .occupancy(a_occ)
    );

    rvdff_pipe_elastic #(
        .WIDTH(8), .DEPTH(1), .REG_READY(0), .RESET_VAL(8'h5A)
    ) u_dut_b (
        .clk(clk), .rst_l(rst_l), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout),
        .occupancy(b_occ)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        a_flush = 0; a_in_valid = 0; a_din = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_din = '0; b_out_ready = 0;
        step(); step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", a_out_valid); end
        checks++; if (a_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_dout: got %h exp deadbeef", a_dout); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", a_occ); end
        rst_l = 1'b1;
        step();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready: got %b exp 1", b_in_ready); end
        // load traffic, then reset asynchronously between clock edges
        a_in_valid = 1; a_din = 32'h77; step();
        a_din = 32'h78; step();
        a_in_valid = 0;
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL midreset_pre_occ: got %0d exp 2", a_occ); end
        #2 rst_l = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b exp 0", a_out_valid); end
        checks++; if (a_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midreset_dout: got %h exp deadbeef", a_dout); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL midreset_occ: got %0d exp 0", a_occ); end
        checks++; if (b_dout !== 8'h5A) begin errors++; $display("FAIL midreset_b_dout: got %h exp 5a", b_dout); end
        @(negedge clk);
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_stream();
        a_out_ready = 1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc < 8) begin
                a_in_valid = 1; a_din = 32'(cyc + 1);
                checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c%0d: got %b exp 1", cyc, a_in_ready); end
            end else begin
                a_in_valid = 0;
            end
            step();
            checks++;
            if (a_out_valid !== ((cyc >= 1) && (cyc <= 8))) begin
                errors++; $display("FAIL stream_valid c%0d: got %b", cyc, a_out_valid);
            end else if (a_out_valid && (a_dout !== 32'(cyc))) begin
                errors++; $display("FAIL stream_data c%0d: got %h exp %h", cyc, a_dout, cyc);
            end
        end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL stream_occ_end: got %0d exp 0", a_occ); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got [4];
        int          n = 0;
        logic        acc;
        a_out_ready = 0;
        a_in_valid = 1; a_din = 32'h1; step();
        a_din = 32'h2; step();
        a_din = 32'h3; step();
        a_din = 32'h4;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b exp 0", a_in_ready); end
        checks++; if (a_occ !== 2'd3) begin errors++; $display("FAIL bp_occ: got %0d exp 3", a_occ); end
        step(); step();
        checks++; if (a_occ !== 2'd3) begin errors++; $display("FAIL bp_occ_hold: got %0d exp 3", a_occ); end
        checks++; if (a_dout !== 32'h1) begin errors++; $display("FAIL bp_dout_hold: got %h exp 1", a_dout); end
        a_out_ready = 1;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_registered: got %b exp 0", a_in_ready); end
        for (int t = 0; t < 10; t++) begin
            if (a_out_valid) begin
                if (n < 4) got[n] = a_dout;
                n++;
            end
            acc = a_in_valid & a_in_ready;
            step();
            if (acc) a_in_valid = 0;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_count: got %0d exp 4", n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[k] !== 32'(k + 1)) begin errors++; $display("FAIL bp_order %0d: got %h exp %h", k, got[k], k + 1); end
        end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL bp_occ_end: got %0d exp 0", a_occ); end
    endtask

    task automatic test_bubble();
        a_out_ready = 0;
        a_in_valid = 1; a_din = 32'hA; step();
        a_in_valid = 0; step();
        a_in_valid = 1; a_din = 32'hB; step();
        a_in_valid = 0;
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL bubble_occ: got %0d exp 2", a_occ); end
        checks++; if (a_dout !== 32'hA || a_out_valid !== 1'b1) begin errors++; $display("FAIL bubble_head: got %b/%h exp 1/a", a_out_valid, a_dout); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready: got %b exp 1", a_in_ready); end
        a_out_ready = 1; step();
        checks++; if (a_dout !== 32'hB || a_out_valid !== 1'b1) begin errors++; $display("FAIL bubble_second: got %b/%h exp 1/b", a_out_valid, a_dout); end
        step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty: got %b exp 0", a_out_valid); end
        a_out_ready = 0;
    endtask

    task automatic test_flush();
        a_out_ready = 0;
        a_in_valid = 1; a_din = 32'h11; step();
        a_din = 32'h22; step();
        a_din = 32'h33; step();
        a_flush = 1; a_din = 32'h44; a_out_ready = 1;
        #1;
        checks++; if (a_out_valid !== 1'b1 || a_dout !== 32'h11) begin errors++; $display("FAIL flush_deliver: got %b/%h exp 1/11", a_out_valid, a_dout); end
        step();
        a_flush = 0; a_in_valid = 0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", a_out_valid); end
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d exp 0", a_occ); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b exp 1", a_in_ready); end
        checks++; if (a_dout !== 32'h11) begin errors++; $display("FAIL flush_payload_kept: got %h exp 11", a_dout); end
        step(); step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b exp 0", a_out_valid); end
        // flush while a beat is being accepted on the input
        a_out_ready = 0;
        a_in_valid = 1; a_din = 32'h55; step();
        a_flush = 1; a_din = 32'h66;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush2_in_ready: got %b exp 1", a_in_ready); end
        step();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush2_occ: got %0d exp 0", a_occ); end
        step(); step();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush2_discard: got %b exp 0", a_out_valid); end
        a_out_ready = 0;
    endtask

    task automatic test_comb_ready();
        logic       mv = 1'b0;
        logic [7:0] md = 8'h00;
        logic [7:0] next_din = 8'h01;
        logic [7:0] exp_emit = 8'h01;
        logic       exp_ready;
        int         accepted = 0;
        int         emitted = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            b_in_valid = 1; b_din = next_din; b_out_ready = cyc[0];
            #1;
            exp_ready = ~mv | b_out_ready;
            checks++; if (b_in_ready !== exp_ready) begin errors++; $display("FAIL comb_ready c%0d: got %b exp %b", cyc, b_in_ready, exp_ready); end
            checks++; if (b_out_valid !== mv) begin errors++; $display("FAIL comb_valid c%0d: got %b exp %b", cyc, b_out_valid, mv); end
            if (mv && b_out_ready) begin
                checks++; if (b_dout !== exp_emit) begin errors++; $display("FAIL comb_order c%0d: got %h exp %h", cyc, b_dout, exp_emit); end
                exp_emit++; emitted++;
            end
            if (exp_ready) begin
                md = next_din; mv = 1'b1; next_din++; accepted++;
            end else if (mv && b_out_ready) begin
                mv = 1'b0;
            end
            step();
        end
        b_in_valid = 0; b_out_ready = 1;
        for (int t = 0; t < 3; t++) begin
            #1;
            if (b_out_valid) begin
                checks++; if (b_dout !== exp_emit) begin errors++; $display("FAIL comb_drain %0d: got %h exp %h", t, b_dout, exp_emit); end
                exp_emit++; emitted++;
            end
            step();
        end
        checks++; if (emitted !== accepted) begin errors++; $display("FAIL comb_count: got %0d exp %0d", emitted, accepted); end
        checks++; if (b_occ !== 2'd0) begin errors++; $display("FAIL comb_occ_end: got %0d exp 0", b_occ); end
        // md holds the last accepted beat; it must be the last one seen at the output
        checks++; if (b_dout !== md) begin errors++; $display("FAIL comb_last_payload: got %h exp %h", b_dout, md); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_comb_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
